// File: rtl/dice_pkg.sv
// Shared types and width helpers for the dice bank.
package dice_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRoll,
        StSum,
        StShow
    } state_e;

    // Bits needed to hold a die value 1..faces.
    function automatic int unsigned die_width(input int unsigned faces);
        return $clog2(faces + 1);
    endfunction

    // Bits needed to hold the total of n dice without overflow.
    function automatic int unsigned sum_width(input int unsigned n, input int unsigned faces);
        return $clog2(n * faces + 1);
    endfunction

endpackage

// File: rtl/dice_die.sv
// Single die: advances by STEP faces per enabled edge, always staying in 1..FACES.
module dice_die
    import dice_pkg::*;
#(
    parameter int unsigned FACES = 6,
    parameter int unsigned STEP  = 1,
    localparam int unsigned W    = die_width(FACES)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         adv_i,
    output logic [W-1:0] val_o
);

    // A step of a whole number of turns is equivalent to its remainder.
    localparam int unsigned StepMod = STEP % FACES;

    logic [W-1:0] val_q, val_d;
    logic [W:0]   sum_ext;

    // Next value: add the reduced step and wrap once past FACES.
    always_comb begin
        sum_ext = {1'b0, val_q} + (W+1)'(StepMod);
        val_d   = val_q;
        if (adv_i) begin
            if (sum_ext > (W+1)'(FACES)) begin
                val_d = W'(sum_ext - (W+1)'(FACES));
            end else begin
                val_d = W'(sum_ext);
            end
        end
    end

    // Die value register; reset shows face 1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            val_q <= W'(1);
        end else begin
            val_q <= val_d;
        end
    end

    assign val_o = val_q;

endmodule

// File: rtl/dice_bank.sv
// Bank of dice rolled by a debounced button; shows a registered total after each roll.
module dice_bank
    import dice_pkg::*;
#(
    parameter int unsigned NUM_DICE = 2,
    parameter int unsigned FACES    = 6,
    parameter int unsigned DEBOUNCE = 4,
    localparam int unsigned W       = die_width(FACES),
    localparam int unsigned S       = sum_width(NUM_DICE, FACES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  button,
    output logic [NUM_DICE*W-1:0] throw,
    output logic [S-1:0]          sum,
    output logic                  valid,
    output logic                  rolling
);

    logic       sync1_q, sync2_q;
    logic       db_q, db_d;
    logic [7:0] cnt_q, cnt_d;
    state_e     state_q, state_d;
    logic       adv;
    logic [S-1:0] total;
    logic [S-1:0] sum_q, sum_d;
    logic         valid_q, valid_d;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: flip only after DEBOUNCE consecutive disagreeing samples.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == 8'(DEBOUNCE - 1)) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Debounce state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    // FSM next state, dice advance enable and result capture.
    always_comb begin
        state_d = state_q;
        adv     = 1'b0;
        sum_d   = sum_q;
        valid_d = 1'b0;
        unique case (state_q)
            StIdle: if (db_q) state_d = StRoll;
            StRoll: begin
                adv = db_q;
                if (!db_q) state_d = StSum;
            end
            StSum: begin
                // SUM always completes, whatever the button does meanwhile.
                state_d = StShow;
                sum_d   = total;
                valid_d = 1'b1;
            end
            StShow: if (db_q) state_d = StRoll;
            default: state_d = StIdle;
        endcase
    end

    // FSM and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            sum_q   <= S'(NUM_DICE);
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            valid_q <= valid_d;
        end
    end

    // Adder over the current die values.
    always_comb begin
        total = '0;
        for (int unsigned k = 0; k < NUM_DICE; k++) begin
            total = total + S'(throw[k*W +: W]);
        end
    end

    for (genvar k = 0; k < NUM_DICE; k++) begin : g_die
        dice_die #(
            .FACES (FACES),
            .STEP  (k + 1)
        ) u_die (
            .clk_i  (clk),
            .rst_ni (rst),
            .adv_i  (adv),
            .val_o  (throw[k*W +: W])
        );
    end

    assign sum     = sum_q;
    assign valid   = valid_q;
    assign rolling = (state_q == StRoll);

endmodule

// File: tb/tb_dice_bank.sv
// Self-checking bench for dice_bank: a small (2x6) instance checked cycle by cycle
// against a behavioural model, and a large (8x15) instance checked on one roll.
module tb_dice_bank;

    localparam int ND_A = 2;
    localparam int F_A  = 6;
    localparam int DEB  = 4;
    localparam int ND_B = 8;
    localparam int F_B  = 15;

    localparam int PH_IDLE = 0;
    localparam int PH_ROLL = 1;
    localparam int PH_SUM  = 2;
    localparam int PH_SHOW = 3;

    logic        clk;
    logic        rst;
    logic        btn_a, btn_b;
    logic [5:0]  throw_a;
    logic [3:0]  sum_a;
    logic        valid_a, rolling_a;
    logic [31:0] throw_b;
    logic [6:0]  sum_b;
    logic        valid_b, rolling_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of instance A.
    int m_s1, m_s2, m_db, m_run, m_ph, m_adv, m_sum, m_valid;

    dice_bank #(.NUM_DICE(ND_A), .FACES(F_A), .DEBOUNCE(DEB)) dut_a (
        .clk     (clk),
        .rst     (rst),
        .button  (btn_a),
        .throw   (throw_a),
        .sum     (sum_a),
        .valid   (valid_a),
        .rolling (rolling_a)
    );

    dice_bank #(.NUM_DICE(ND_B), .FACES(F_B), .DEBOUNCE(DEB)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .button  (btn_b),
        .throw   (throw_b),
        .sum     (sum_b),
        .valid   (valid_b),
        .rolling (rolling_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int die_val(input int adv, input int k, input int faces);
        return 1 + ((adv * (k + 1)) % faces);
    endfunction

    function automatic logic [5:0] exp_throw_a();
        logic [5:0] t;
        t = '0;
        for (int k = 0; k < ND_A; k++) t[k*3 +: 3] = 3'(die_val(m_adv, k, F_A));
        return t;
    endfunction

    function automatic int dice_total_a();
        int s;
        s = 0;
        for (int k = 0; k < ND_A; k++) s += die_val(m_adv, k, F_A);
        return s;
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0;
        m_ph = PH_IDLE; m_adv = 0; m_sum = ND_A; m_valid = 0;
    endtask

    // One clock edge of the spec rules, all evaluated on pre-edge values.
    task automatic model_step();
        int ph_old, db_old, bs;
        ph_old = m_ph;
        db_old = m_db;
        bs     = m_s2;
        if (ph_old == PH_ROLL && db_old == 1) m_adv++;
        case (ph_old)
            PH_IDLE: if (db_old == 1) m_ph = PH_ROLL;
            PH_ROLL: if (db_old == 0) m_ph = PH_SUM;
            PH_SUM:  m_ph = PH_SHOW;
            default: if (db_old == 1) m_ph = PH_ROLL;
        endcase
        m_valid = (ph_old == PH_SUM) ? 1 : 0;
        if (ph_old == PH_SUM) m_sum = dice_total_a();
        if (bs != m_db) begin
            m_run++;
            if (m_run == DEB) begin
                m_db  = bs;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = int'(btn_a);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_reset();
        else model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; btn_a = 1'b0; btn_b = 1'b0;
        model_reset();
        repeat (3) tick();
        n_tests++;
        if (throw_a !== 6'b001_001) begin
            n_fail++; $display("FAIL reset_throw_a: got %h want %h", throw_a, 6'b001_001);
        end
        n_tests++;
        if (sum_a !== 4'd2) begin
            n_fail++; $display("FAIL reset_sum_a: got %0d want 2", sum_a);
        end
        n_tests++;
        if (valid_a !== 1'b0 || rolling_a !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags_a: valid %b rolling %b want 0 0", valid_a, rolling_a);
        end
        n_tests++;
        if (throw_b !== 32'h1111_1111 || sum_b !== 7'd8) begin
            n_fail++; $display("FAIL reset_b: throw %h sum %0d want 11111111 8", throw_b, sum_b);
        end
        rst = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_glitch();
        btn_a = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i == 3) btn_a = 1'b0;
            tick();
            n_tests++;
            if (rolling_a !== 1'b0 || throw_a !== 6'b001_001) begin
                n_fail++;
                $display("FAIL glitch: cycle %0d rolling %b throw %h want 0 %h",
                         i, rolling_a, throw_a, 6'b001_001);
            end
        end
    endtask

    task automatic test_roll7();
        int pulses;
        pulses = 0;
        btn_a  = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (i == 8) btn_a = 1'b0;
            tick();
            if (valid_a === 1'b1) pulses++;
            n_tests++;
            if (throw_a !== exp_throw_a() || sum_a !== 4'(m_sum) ||
                valid_a !== 1'(m_valid) || rolling_a !== (m_ph == PH_ROLL)) begin
                n_fail++;
                $display("FAIL roll7_model: cycle %0d got t=%h s=%0d v=%b r=%b want t=%h s=%0d v=%0d r=%0d",
                         i, throw_a, sum_a, valid_a, rolling_a, exp_throw_a(), m_sum, m_valid,
                         m_ph == PH_ROLL);
            end
        end
        n_tests++;
        if (throw_a[2:0] !== 3'd2 || throw_a[5:3] !== 3'd3 || sum_a !== 4'd5) begin
            n_fail++;
            $display("FAIL roll7_result: die0 %0d die1 %0d sum %0d want 2 3 5",
                     throw_a[2:0], throw_a[5:3], sum_a);
        end
        n_tests++;
        if (pulses != 1 || rolling_a !== 1'b0) begin
            n_fail++; $display("FAIL roll7_pulse: pulses %0d rolling %b want 1 0", pulses, rolling_a);
        end
    endtask

    task automatic test_repress();
        int pulses;
        int seen_roll;
        pulses = 0; seen_roll = 0;
        btn_a  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) btn_a = 1'b0;
            tick();
            if (valid_a === 1'b1) pulses++;
            if (rolling_a === 1'b1) begin
                seen_roll = 1;
                n_tests++;
                if (sum_a !== 4'd5) begin
                    n_fail++; $display("FAIL repress_hold: sum %0d want 5 while rolling", sum_a);
                end
            end
            n_tests++;
            if (throw_a !== exp_throw_a() || sum_a !== 4'(m_sum) || valid_a !== 1'(m_valid)) begin
                n_fail++;
                $display("FAIL repress_model: cycle %0d got t=%h s=%0d v=%b want t=%h s=%0d v=%0d",
                         i, throw_a, sum_a, valid_a, exp_throw_a(), m_sum, m_valid);
            end
        end
        // 7 earlier advances plus 4 more: die0 = 1+11%6, die1 = 1+22%6.
        n_tests++;
        if (pulses != 1 || seen_roll != 1 || sum_a !== 4'd11 || throw_a !== {3'd5, 3'd6}) begin
            n_fail++;
            $display("FAIL repress_result: pulses %0d rolled %0d sum %0d throw %h want 1 1 11 %h",
                     pulses, seen_roll, sum_a, throw_a, {3'd5, 3'd6});
        end
    endtask

    task automatic test_reset_mid_roll();
        btn_a = 1'b1;
        repeat (10) tick();
        n_tests++;
        if (rolling_a !== 1'b1) begin
            n_fail++; $display("FAIL midroll_entry: rolling %b want 1", rolling_a);
        end
        #2 rst = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (throw_a !== 6'b001_001 || valid_a !== 1'b0 || rolling_a !== 1'b0 || sum_a !== 4'd2) begin
            n_fail++;
            $display("FAIL midroll_async: throw %h valid %b rolling %b sum %0d want 09 0 0 2",
                     throw_a, valid_a, rolling_a, sum_a);
        end
        btn_a = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++;
            if (valid_a !== 1'b0 || rolling_a !== 1'b0 || throw_a !== 6'b001_001) begin
                n_fail++;
                $display("FAIL midroll_after: cycle %0d valid %b rolling %b throw %h want 0 0 09",
                         i, valid_a, rolling_a, throw_a);
            end
        end
    endtask

    task automatic test_random();
        int len;
        for (int seg = 0; seg < 60; seg++) begin
            btn_a = 1'($urandom_range(0, 1));
            len   = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                tick();
                n_tests++;
                if (throw_a !== exp_throw_a() || sum_a !== 4'(m_sum) ||
                    valid_a !== 1'(m_valid) || rolling_a !== (m_ph == PH_ROLL)) begin
                    n_fail++;
                    $display("FAIL random: seg %0d got t=%h s=%0d v=%b r=%b want t=%h s=%0d v=%0d r=%0d",
                             seg, throw_a, sum_a, valid_a, rolling_a, exp_throw_a(), m_sum,
                             m_valid, m_ph == PH_ROLL);
                end
            end
        end
    endtask

    task automatic test_big();
        int found;
        int exp_total;
        logic [3:0] exp_die;
        found = 0;
        btn_b = 1'b1;
        repeat (15) tick();
        btn_b = 1'b0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            tick();
            if (valid_b === 1'b1) found = 1;
        end
        n_tests++;
        if (found == 0) begin
            n_fail++; $display("FAIL big_valid: no valid pulse within 20 cycles");
        end
        exp_total = 0;
        for (int k = 0; k < ND_B; k++) begin
            exp_die = 4'(die_val(14, k, F_B));
            exp_total += int'(exp_die);
            n_tests++;
            if (throw_b[k*4 +: 4] !== exp_die) begin
                n_fail++; $display("FAIL big_die%0d: got %0d want %0d", k, throw_b[k*4 +: 4], exp_die);
            end
        end
        n_tests++;
        if (sum_b !== 7'(exp_total) || rolling_b !== 1'b0) begin
            n_fail++;
            $display("FAIL big_sum: sum %0d rolling %b want %0d 0", sum_b, rolling_b, exp_total);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_roll7();
        test_repress();
        test_reset_mid_roll();
        test_random();
        test_big();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dice_bank.md
DICE_BANK -- requirements
Module: dice_bank

Interface
REQ-001 Parameter NUM_DICE, default 2, number of dice channels (1..8) SHALL be supported.
REQ-002 Parameter FACES, default 6, faces per die (2..15) SHALL be supported.
REQ-003 Parameter DEBOUNCE, default 4, cycles of stable button required (1..255) SHALL be supported.
REQ-004 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 button  input  1  asynchronous roll request; high = rolling.
REQ-007 throw  output  NUM_DICE*W  die values, die k at bits [k*W +: W], W = clog2(FACES+1).
REQ-008 sum  output  S  registered sum of all dice, S = clog2(NUM_DICE*FACES+1).
REQ-009 valid  output  1  one-cycle pulse when a new result is shown.
REQ-010 rolling  output  1  high exactly while FSM is in ROLL.

Function
REQ-011 button SHALL pass through a 2-flop synchroniser; the result is btn_s.
REQ-012 The debounced level btn_db SHALL change only after btn_s differs from btn_db on DEBOUNCE consecutive edges; any agreeing cycle SHALL clear the debounce counter.
REQ-013 The FSM SHALL have states IDLE, ROLL, SUM, SHOW.
REQ-014 IDLE -> ROLL and SHOW -> ROLL on an edge where btn_db=1; otherwise hold.
REQ-015 ROLL -> SUM on an edge where btn_db=0; SUM -> SHOW unconditionally after one cycle.
REQ-016 Die k SHALL advance at every edge where state=ROLL and btn_db=1, by k+1 faces: next = ((v-1+k+1) mod FACES)+1.
REQ-017 Die values SHALL always stay in 1..FACES; FACES wraps to 1 with no illegal value ever output.
REQ-018 Dice SHALL be frozen in IDLE, SUM and SHOW.
REQ-019 sum SHALL be loaded at the SUM->SHOW edge with the unsigned sum of frozen dice, no overflow (S bits sufficient).
REQ-020 valid SHALL be 1 for exactly the first cycle in SHOW, 0 otherwise.
REQ-021 sum and throw SHALL hold the last result through SHOW and into the next ROLL (sum unchanged until next SUM).
REQ-022 A button glitch shorter than DEBOUNCE cycles after synchronisation SHALL cause no state change.
REQ-023 btn_db rising in the same cycle as SUM SHALL be ignored until SHOW is reached (SUM always completes).

Reset
REQ-024 While rst=0: every die = 1, sum = NUM_DICE, valid = 0, rolling = 0, state = IDLE, synchroniser and btn_db = 0, debounce counter = 0.
REQ-025 Reset asserted mid-ROLL or mid-SUM SHALL abort immediately with no valid pulse; release SHALL resume from IDLE on the next edge.

Structure
REQ-026 Package dice_pkg SHALL hold the FSM state type and width helpers for W and S.
REQ-027 Single-die stepper SHALL be sub-module dice_die (parameters FACES, STEP), instantiated NUM_DICE times via generate.
REQ-028 Synchroniser, debouncer, FSM and adder SHALL reside in dice_bank.

Verification
REQ-029 Reset with NUM_DICE=2, FACES=6: throw={1,1}, sum=2, valid=0, rolling=0.
REQ-030 Button held to give exactly 7 advancing edges, then released: die0=2, die1=3, sum=5, single valid pulse, rolling low after release.
REQ-031 DEBOUNCE=4, button pulse of 3 cycles in IDLE: rolling stays 0, throw stays {1,1}.
REQ-032 rst driven low during ROLL: throw returns to {1,1} asynchronously, no valid pulse, IDLE after release.
REQ-033 NUM_DICE=8, FACES=15, roll with 14 advancing edges: die k = ((14*(k+1)) mod 15)+1, i.e. 15,14,...,8; sum=92 in 7-bit sum.
REQ-034 Press again in SHOW: previous sum held until new SUM, second valid pulse with new value.
